// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store RMW initiator: access widths, FSM states and the
// word-alignment mask.
package lsu_pkg;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_RESP = 2'b11
    } state_e;

    // Byte offset inside the word, with bits below the access size dropped.
    function automatic logic [1:0] lane_off(input logic [1:0] width, input logic [1:0] addr_lo);
        logic [1:0] off;
        case (width)
            W_BYTE:  off = addr_lo;
            W_HALF:  off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane logic for sub-word accesses: extracts and extends load data, and merges store
// data into the previously read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  width,
    input  logic        sign,
    input  logic [1:0]  off,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rd_word[{off, 3'b000} +: 8];
    assign half_v = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        merged  = st_data;
        case (width)
            W_BYTE: begin
                ld_data = {{24{sign & byte_v[7]}}, byte_v};
                merged  = rd_word;
                merged[{off, 3'b000} +: 8] = st_data[7:0];
            end
            W_HALF: begin
                ld_data = {{16{sign & half_v[15]}}, half_v};
                merged  = off[1] ? {st_data[15:0], rd_word[15:0]}
                                 : {rd_word[31:16], st_data[15:0]};
            end
            default: begin
                ld_data = rd_word;
                merged  = st_data;
            end
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
// Optional alignment/width fault reporting is enabled by defining ALIGN_CHECK_EN.
//
// state  | meaning
// S_IDLE | ready for a request
// S_RD   | memory read: load data capture, or old word fetch for sb/sh
// S_WR   | memory write of full word (sw) or merged word (sb/sh)
// S_RESP | one-cycle completion pulse
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK = 32'h0000_3FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [31:0] mem_pc
);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_exc_q, resp_exc_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [31:0] mem_pc_q, mem_pc_d;
    logic        op_we_q, op_we_d;
    logic [1:0]  op_width_q, op_width_d;
    logic        op_sign_q, op_sign_d;
    logic [1:0]  op_off_q, op_off_d;
    logic [31:0] op_wdata_q, op_wdata_d;

    logic        accept;
    logic        fault;
    logic [1:0]  width_n;
    logic [31:0] ld_data;
    logic [31:0] merged;

`ifdef ALIGN_CHECK_EN
    assign fault   = (req_width == W_RSVD)
                   || ((req_width == W_HALF) && req_addr[0])
                   || ((req_width == W_WORD) && (req_addr[1:0] != 2'b00));
    assign width_n = req_width;
`else
    assign fault   = 1'b0;
    assign width_n = (req_width == W_RSVD) ? W_WORD : req_width;
`endif

    assign accept = req_valid & req_ready_q;

    lsu_lane u_lane (
        .width   (op_width_q),
        .sign    (op_sign_q),
        .off     (op_off_q),
        .rd_word (mem_rd),
        .st_data (op_wdata_q),
        .ld_data (ld_data),
        .merged  (merged)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_exc_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        mem_pc_d     = mem_pc_q;
        op_we_d      = op_we_q;
        op_width_d   = op_width_q;
        op_sign_d    = op_sign_q;
        op_off_d     = op_off_q;
        op_wdata_d   = op_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mem_pc_d   = req_pc;
                    op_we_d    = req_we;
                    op_width_d = width_n;
                    op_sign_d  = req_sign;
                    op_off_d   = lane_off(width_n, req_addr[1:0]);
                    op_wdata_d = req_wdata;
                    if (fault) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        mem_addr_d = req_addr & ADDR_MASK & WORD_ADDR_MASK;
                        // Full-word stores skip the read; nothing to merge.
                        if (req_we && (width_n == W_WORD)) begin
                            state_d  = S_WR;
                            mem_we_d = 1'b1;
                            mem_wd_d = req_wdata;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (op_we_q) begin
                    state_d  = S_WR;
                    mem_we_d = 1'b1;
                    mem_wd_d = merged;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_exc_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wd_q     <= 32'h0;
            mem_pc_q     <= 32'h0;
            op_we_q      <= 1'b0;
            op_width_q   <= W_WORD;
            op_sign_q    <= 1'b0;
            op_off_q     <= 2'b00;
            op_wdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            mem_pc_q     <= mem_pc_d;
            op_we_q      <= op_we_d;
            op_width_q   <= op_width_d;
            op_sign_q    <= op_sign_d;
            op_off_q     <= op_off_d;
            op_wdata_q   <= op_wdata_d;
        end
    end

    // Write enable drops in the reset cycle itself so an abandoned RMW never lands.
    assign mem_we     = mem_we_q & ~reset;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_exc   = resp_exc_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign mem_pc     = mem_pc_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed cases plus randomized traffic against an
// arithmetic reference model of the memory and load/store semantics.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_width;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] mem_pc;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_rmw dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_width  (req_width),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .mem_pc     (mem_pc)
    );

    assign mem_rd = mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[13:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: expected latency, load result, fault flag and written word; updates ref_mem.
    task automatic model(input logic we, input logic [1:0] width, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic exc,
                         output int nwr, output logic [31:0] wd);
        logic [1:0]  w;
        logic        flt;
        int          idx;
        int          bsh;
        int          hsh;
        logic [31:0] word;
        logic [31:0] v;
        w    = width;
        idx  = int'((addr & 32'h3FFF) >> 2);
        bsh  = 8 * int'(addr % 4);
        hsh  = 16 * int'((addr / 2) % 2);
        word = ref_mem[idx];
        flt  = 1'b0;
`ifdef ALIGN_CHECK_EN
        flt = (w == 2'd3) || (w == 2'd1 && addr % 2 != 0) || (w == 2'd0 && addr % 4 != 0);
`else
        if (w == 2'd3) w = 2'd0;
`endif
        wd = 32'h0;
        if (flt) begin
            lat = 1; rdata = 32'h0; exc = 1'b1; nwr = 0;
        end else if (!we) begin
            lat = 2; exc = 1'b0; nwr = 0;
            if (w == 2'd2) begin
                v = (word >> bsh) & 32'hFF;
                if (sign && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end else if (w == 2'd1) begin
                v = (word >> hsh) & 32'hFFFF;
                if (sign && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end else begin
                v = word;
            end
            rdata = v;
        end else begin
            exc = 1'b0; rdata = 32'h0; nwr = 1;
            if (w == 2'd2) begin
                lat = 3;
                wd  = (word & ~(32'hFF << bsh)) | ((wdata & 32'hFF) << bsh);
            end else if (w == 2'd1) begin
                lat = 3;
                wd  = (word & ~(32'hFFFF << hsh)) | ((wdata & 32'hFFFF) << hsh);
            end else begin
                lat = 2;
                wd  = wdata;
            end
            ref_mem[idx] = wd;
        end
    endtask

    task automatic run_op(input string tag, input logic we, input logic [1:0] width,
                          input logic sign, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc);
        int          lat, exp_nwr, nwr, cyc;
        logic [31:0] exp_rd, exp_wd, got_rd, got_wd, got_wa;
        logic        exp_exc, got_exc, got_ready, done;
        model(we, width, sign, addr, wdata, lat, exp_rd, exp_exc, exp_nwr, exp_wd);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_width = width; req_sign = sign;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        @(posedge clk);
        #1;
        // Keep a scrambled request pending: it must not be accepted nor disturb the latched op.
        req_we = 1'($urandom); req_width = 2'($urandom); req_sign = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
        cyc = 0; done = 1'b0; nwr = 0;
        got_rd = 32'hX; got_exc = 1'bX; got_wd = 32'h0; got_wa = 32'h0; got_ready = 1'b1;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                nwr++; got_wd = mem_wd; got_wa = mem_addr;
            end
            if (resp_valid) begin
                done = 1'b1; got_rd = resp_rdata; got_exc = resp_exc; got_ready = req_ready;
            end
        end
        req_valid = 1'b0;
        check({tag, "_latency"}, done ? 32'(cyc) : 32'd99, 32'(lat));
        check({tag, "_rdata"}, got_rd, exp_rd);
        check({tag, "_exc"}, {31'd0, got_exc}, {31'd0, exp_exc});
        check({tag, "_ready_resp"}, {31'd0, got_ready}, 32'd0);
        check({tag, "_nwrites"}, 32'(nwr), 32'(exp_nwr));
        if (exp_nwr == 1) begin
            check({tag, "_wdata"}, got_wd, exp_wd);
            check({tag, "_waddr"}, got_wa, addr & 32'h3FFC);
        end
        check({tag, "_pc"}, mem_pc, pc);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_hold"}, resp_rdata, exp_rd);
    endtask

    initial begin
        int idx_a;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_exc", {31'd0, resp_exc}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_pc", mem_pc, 32'h0);
        reset = 1'b0;

        run_op("lb_11",  1'b0, 2'b10, 1'b1, 32'h11, 32'h0, 32'h100);
        run_op("lhu_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h104);
        run_op("lh_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h108);
        run_op("sb_13",  1'b1, 2'b10, 1'b0, 32'h13, 32'h55, 32'h10C);
        check("sb_13_mem", mem[4], 32'h5599_AABB);
        run_op("sw_20",  1'b1, 2'b00, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h110);
        run_op("lw_22",  1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h114);
        run_op("rsvd_ld", 1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 32'h118);
        run_op("lbu_hi", 1'b0, 2'b10, 1'b0, 32'hFFFF_C013, 32'h0, 32'h11C);

        for (int i = 0; i < 200; i++) begin
            run_op($sformatf("r%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom & 32'hFFFF_C07F, $urandom, $urandom);
        end

        // Reset landing in the write cycle of a halfword RMW.
        idx_a = 4;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_width = 2'b01; req_sign = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000_CAFE; req_pc = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_we_in_wr", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_we_gated", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_mem", mem[idx_a], ref_mem[idx_a]);
        @(negedge clk);
        check("rst_mid_resp2", {31'd0, resp_valid}, 32'd0);

        run_op("post_rst_lw", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h204);

        for (int i = 0; i < 32; i++) begin
            check($sformatf("mem_w%0d", i), mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
